// File: rtl/proc_multicycle_param.sv
// Parametrised multi-cycle datapath core with a valid/ready instruction port and a registered output bus.
// Optional macro PROC_FLAGS_EN adds zero/carry flag outputs.
module proc_multicycle_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] iin,
  input  logic              iin_valid,
  output logic              iin_ready,
  output logic [DATA_W-1:0] bus,
  output logic              bus_valid,
  output logic              busy
`ifdef PROC_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  localparam int REG_AW = $clog2(NREGS);
  localparam int IMM_W  = DATA_W - 4 - REG_AW;

  localparam logic [3:0] OP_LDI  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_MV   = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] bus_q;
  logic              bus_valid_q;
  logic              ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [3:0]        in_op_s;
  logic [3:0]        op_s;
  logic [REG_AW-1:0] rx_s;
  logic [REG_AW-1:0] ry_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] rx_val_s;
  logic [DATA_W-1:0] ry_val_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] r_d;

`ifdef PROC_FLAGS_EN
  logic              c_q;
  logic              c_d;
  logic              flag_z_q;
  logic              flag_c_q;
`endif

  assign in_op_s  = iin[DATA_W-1 -: 4];
  assign op_s     = ir_q[DATA_W-1 -: 4];
  assign rx_s     = ir_q[DATA_W-5 -: REG_AW];
  assign ry_s     = ir_q[DATA_W-5-REG_AW -: REG_AW];
  assign imm_s    = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign rx_val_s = regs_q[rx_s];
  assign ry_val_s = regs_q[ry_s];

  // Operand selection: A source for S_LOADA, B source for the ALU.
  always_comb begin
    b_s = (op_s == OP_ADDI) ? imm_s : ry_val_s;
    a_d = rx_val_s;
    case (op_s)
      OP_LDI:  a_d = imm_s;
      OP_MV:   a_d = ry_val_s;
      default: a_d = rx_val_s;
    endcase
  end

  // ALU; LDI and MV fall through to pass-A.
  always_comb begin
    r_d = a_q;
    case (op_s)
      OP_ADD, OP_ADDI: r_d = a_q + b_s;
      OP_SUB:          r_d = a_q - b_s;
      OP_AND:          r_d = a_q & b_s;
      OP_OR:           r_d = a_q | b_s;
      OP_XOR:          r_d = a_q ^ b_s;
      OP_SLT:          r_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_s))};
      default:         r_d = a_q;
    endcase
  end

`ifdef PROC_FLAGS_EN
  // Carry/no-borrow; an unsigned sum that wrapped is smaller than its addend.
  always_comb begin
    c_d = 1'b0;
    case (op_s)
      OP_ADD, OP_ADDI: c_d = (r_d < a_q);
      OP_SUB:          c_d = (a_q >= b_s);
      default:         c_d = 1'b0;
    endcase
  end
`endif

  // Control FSM, datapath registers and register file.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      a_q         <= '0;
      r_q         <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef PROC_FLAGS_EN
      c_q      <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      bus_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iin_valid && ready_q) begin
            ir_q <= iin;
            if (in_op_s == OP_OUT) begin
              state_q <= S_OUT;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else if (in_op_s >= OP_NOP) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_LOADA;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOADA: begin
          a_q     <= a_d;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          r_q     <= r_d;
`ifdef PROC_FLAGS_EN
          c_q     <= c_d;
`endif
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          regs_q[rx_s] <= r_q;
`ifdef PROC_FLAGS_EN
          if (op_s >= OP_ADD && op_s <= OP_SLT) begin
            flag_z_q <= (r_q == '0);
            flag_c_q <= c_q;
          end
`endif
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_OUT: begin
          bus_q       <= rx_val_s;
          bus_valid_q <= 1'b1;
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign iin_ready = ready_q;
  assign busy      = busy_q;
  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
`ifdef PROC_FLAGS_EN
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
`endif

endmodule

// File: tb/tb_proc_multicycle_param.sv
// Directed self-checking bench for proc_multicycle_param (16/8 default instance plus a 32/16 instance).
// Flag checks are compiled in when PROC_FLAGS_EN is defined.
module tb_proc_multicycle_param;

  logic        clock;
  logic        resetn;
  logic [15:0] iin;
  logic        iin_valid;
  logic        iin_ready;
  logic [15:0] bus;
  logic        bus_valid;
  logic        busy;
  logic [31:0] iin32;
  logic        iin_valid32;
  logic        ready32;
  logic [31:0] bus32;
  logic        bv32;
  logic        busy32;
`ifdef PROC_FLAGS_EN
  logic        flag_z, flag_c, flag_z32, flag_c32;
`endif

  int checks   = 0;
  int failures = 0;

  proc_multicycle_param dut (
    .clock(clock), .resetn(resetn), .iin(iin), .iin_valid(iin_valid),
    .iin_ready(iin_ready), .bus(bus), .bus_valid(bus_valid), .busy(busy)
`ifdef PROC_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  proc_multicycle_param #(.DATA_W(32), .NREGS(16)) dut32 (
    .clock(clock), .resetn(resetn), .iin(iin32), .iin_valid(iin_valid32),
    .iin_ready(ready32), .bus(bus32), .bus_valid(bv32), .busy(busy32)
`ifdef PROC_FLAGS_EN
    , .flag_z(flag_z32), .flag_c(flag_c32)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction at a negedge and wait (bounded) until iin_ready returns.
  task automatic run(input logic [31:0] instr, input bit w32, output int busy_cyc,
                     output int pulses, output logic [31:0] last_bus);
    bit done;
    busy_cyc = 0; pulses = 0; last_bus = 32'd0; done = 1'b0;
    if (w32) begin iin32 = instr; iin_valid32 = 1'b1; end
    else begin iin = instr[15:0]; iin_valid = 1'b1; end
    @(negedge clock);
    iin_valid = 1'b0; iin_valid32 = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (w32 ? bv32 : bus_valid) begin
        pulses++;
        last_bus = w32 ? bus32 : {16'd0, bus};
      end
      if (w32 ? busy32 : busy) busy_cyc++;
      if (w32 ? ready32 : iin_ready) done = 1'b1;
      else @(negedge clock);
    end
    chk("complete", {31'd0, done}, 32'd1);
  endtask

  task automatic alu(input string tag, input logic [31:0] instr, input bit w32);
    int bc, np; logic [31:0] lb;
    run(instr, w32, bc, np, lb);
    chk({tag, "_busy_cycles"}, bc, 32'd3);
  endtask

  task automatic out_chk(input string tag, input logic [31:0] instr, input bit w32, input logic [31:0] exp);
    int bc, np; logic [31:0] lb;
    run(instr, w32, bc, np, lb);
    chk({tag, "_pulses"}, np, 32'd1);
    chk({tag, "_bus"}, lb, exp);
    @(negedge clock);
    chk({tag, "_valid_drop"}, {31'd0, (w32 ? bv32 : bus_valid)}, 32'd0);
    chk({tag, "_bus_hold"}, (w32 ? bus32 : {16'd0, bus}), exp);
  endtask

`ifdef PROC_FLAGS_EN
  task automatic chk_flags(input string tag, input logic ez, input logic ec);
    chk({tag, "_flag_z"}, {31'd0, flag_z}, {31'd0, ez});
    chk({tag, "_flag_c"}, {31'd0, flag_c}, {31'd0, ec});
  endtask
`endif

  initial begin
    int np;
    resetn = 1'b0; iin = 16'd0; iin_valid = 1'b0; iin32 = 32'd0; iin_valid32 = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, iin_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus", {16'd0, bus}, 32'd0);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", {31'd0, iin_ready}, 32'd1);
`ifdef PROC_FLAGS_EN
    chk_flags("rst", 1'b0, 1'b0);
`endif

    alu("ldi_r1_5", 32'h0205, 1'b0);
    alu("ldi_r2_m3", 32'h05FD, 1'b0);
    alu("add_r1_r2", 32'h1280, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("add_r1_r2", 1'b0, 1'b1);
`endif
    out_chk("out_r1_a", 32'h8200, 1'b0, 32'h0002);

    alu("ldi_r3_0", 32'h0600, 1'b0);
    alu("sub_r3_r1", 32'h2640, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("sub_r3_r1", 1'b0, 1'b0);
`endif
    out_chk("out_r3", 32'h8600, 1'b0, 32'hFFFE);

    // NOP: accepted without leaving S_IDLE
    iin = 16'hA000; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0;
    chk("nop_ready", {31'd0, iin_ready}, 32'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("nop_bus", {16'd0, bus}, 32'hFFFE);

    alu("addi_r1_m2", 32'h63FE, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("addi_r1_m2", 1'b1, 1'b1);
`endif
    out_chk("out_r1_b", 32'h8200, 1'b0, 32'h0000);

    alu("ldi_r4", 32'h08F0, 1'b0);
    alu("ldi_r5", 32'h0A3C, 1'b0);
    alu("and_r4_r5", 32'h3940, 1'b0);
    out_chk("out_and", 32'h8800, 1'b0, 32'h0030);
    alu("or_r5_r4", 32'h4B00, 1'b0);
    out_chk("out_or", 32'h8A00, 1'b0, 32'h003C);
    alu("xor_r5_r2", 32'h5A80, 1'b0);
    out_chk("out_xor", 32'h8A00, 1'b0, 32'hFFC1);
    alu("slt_r2_r4", 32'h7500, 1'b0);
    out_chk("out_slt_true", 32'h8400, 1'b0, 32'h0001);
    alu("slt_r4_r3", 32'h78C0, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("slt_r4_r3", 1'b1, 1'b0);
`endif
    out_chk("out_slt_false", 32'h8800, 1'b0, 32'h0000);
    alu("mv_r6_r5", 32'h9D40, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("mv_held", 1'b1, 1'b0);
`endif
    out_chk("out_mv", 32'h8C00, 1'b0, 32'hFFC1);
    alu("add_r6_r6", 32'h1D80, 1'b0);
`ifdef PROC_FLAGS_EN
    chk_flags("add_r6_r6", 1'b0, 1'b1);
`endif
    out_chk("out_add_carry", 32'h8C00, 1'b0, 32'hFF82);
    alu("ldi_r7_min", 32'h0F00, 1'b0);
    out_chk("out_r7", 32'h8E00, 1'b0, 32'hFF00);
    alu("ldi_r0_max", 32'h00FF, 1'b0);
    out_chk("out_r0", 32'h8000, 1'b0, 32'h00FF);
    alu("sub_r0_r0", 32'h2000, 1'b0);
    out_chk("out_r0_zero", 32'h8000, 1'b0, 32'h0000);
`ifdef PROC_FLAGS_EN
    chk_flags("sub_r0_r0", 1'b1, 1'b1);
`endif

    // Streaming: iin_valid held high for 12 cycles issues exactly 3 ADDs
    alu("ldi_r1_1", 32'h0201, 1'b0);
    alu("ldi_r2_1", 32'h0401, 1'b0);
    np = 0;
    iin = 16'h1280; iin_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (iin_ready) np++;
      @(negedge clock);
    end
    iin_valid = 1'b0;
    chk("stream_ready_pulses", np, 32'd3);
    out_chk("stream_r1", 32'h8200, 1'b0, 32'h0004);

    // Reset asserted while an ADD sits in S_EXEC
    iin = 16'h1280; iin_valid = 1'b1;
    @(negedge clock);
    iin_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_bus", {16'd0, bus}, 32'd0);
    chk("midrst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("midrst_ready_release", {31'd0, iin_ready}, 32'd1);
    @(negedge clock);
    chk("midrst_ready_next", {31'd0, iin_ready}, 32'd1);
`ifdef PROC_FLAGS_EN
    chk_flags("midrst", 1'b0, 1'b0);
`endif
    out_chk("midrst_r1", 32'h8200, 1'b0, 32'h0000);
    out_chk("midrst_r2", 32'h8400, 1'b0, 32'h0000);

    // Wide configuration: DATA_W=32, NREGS=16
    alu("w32_ldi_r15", 32'h0FFFFFFF, 1'b1);
    out_chk("w32_out_r15", 32'h8F000000, 1'b1, 32'hFFFFFFFF);
    alu("w32_add_r15", 32'h1FF00000, 1'b1);
    out_chk("w32_out_sum", 32'h8F000000, 1'b1, 32'hFFFFFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
